// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared definitions for the LFSR noise generator family.
//   - DEFAULT_SEED   : nonzero start value used when no seed is given
//   - default_taps() : maximal-length Fibonacci tap masks for widths 3..32
//   - lfsr_step()    : one Fibonacci shift on a 32-bit container; callers
//                      zero-extend their state and truncate the result
package lfsr_pkg;

  typedef logic [31:0] lfsr_word_t;

  localparam lfsr_word_t DEFAULT_SEED = 32'd1;
  localparam int         MIN_WIDTH    = 3;
  localparam int         MAX_WIDTH    = 32;

  // Bit i of a mask set means state[i] feeds the new bit 0.
  function automatic lfsr_word_t default_taps(input int width);
    lfsr_word_t t;
    case (width)
      3:       t = 32'h0000_0006;
      4:       t = 32'h0000_000C;
      5:       t = 32'h0000_0014;
      6:       t = 32'h0000_0030;
      7:       t = 32'h0000_0060;
      8:       t = 32'h0000_00B8;
      9:       t = 32'h0000_0110;
      10:      t = 32'h0000_0240;
      11:      t = 32'h0000_0500;
      12:      t = 32'h0000_0829;
      13:      t = 32'h0000_100D;
      14:      t = 32'h0000_2015;
      15:      t = 32'h0000_6000;
      16:      t = 32'h0000_D008;
      17:      t = 32'h0001_2000;
      18:      t = 32'h0002_0400;
      19:      t = 32'h0004_0023;
      20:      t = 32'h0009_0000;
      21:      t = 32'h0014_0000;
      22:      t = 32'h0030_0000;
      23:      t = 32'h0042_0000;
      24:      t = 32'h00E1_0000;
      25:      t = 32'h0120_0000;
      26:      t = 32'h0200_0023;
      27:      t = 32'h0400_0013;
      28:      t = 32'h0900_0000;
      29:      t = 32'h1400_0000;
      30:      t = 32'h2000_0029;
      31:      t = 32'h4800_0000;
      32:      t = 32'h8020_0003;
      default: t = 32'h0000_0000;
    endcase
    return t;
  endfunction

  // Shift up by one and insert the parity of the tapped bits at bit 0.
  // The bit shifted out of the top of a narrow state lands above WIDTH
  // and is dropped by the caller's truncation.
  function automatic lfsr_word_t lfsr_step(input lfsr_word_t state,
                                           input lfsr_word_t taps);
    return {state[30:0], ^(state & taps)};
  endfunction

endpackage

// File: rtl/lfsr_multi_step.sv
// lfsr_multi_step: purely combinational SHIFTS-fold unrolled LFSR advance.
// Ports:
//   state_in  (in,  WIDTH) current LFSR state
//   state_out (out, WIDTH) state after SHIFTS single steps
module lfsr_multi_step
  import lfsr_pkg::*;
#(
  parameter int         WIDTH  = 8,
  parameter lfsr_word_t TAPS   = 32'h0000_00B8,
  parameter int         SHIFTS = 1
) (
  input  logic [WIDTH-1:0] state_in,
  output logic [WIDTH-1:0] state_out
);

  logic [WIDTH-1:0] chain [SHIFTS+1];

  assign chain[0] = state_in;

  for (genvar i = 0; i < SHIFTS; i++) begin : g_step
    assign chain[i+1] = WIDTH'(lfsr_step(lfsr_word_t'(chain[i]), TAPS));
  end

  assign state_out = chain[SHIFTS];

endmodule

// File: rtl/lfsr_noise_gen.sv
// lfsr_noise_gen: parametrised Fibonacci LFSR pseudo-noise source with a
// valid/ready output stream, runtime seed load and zero-seed protection.
// Ports:
//   clock       (in)         system clock
//   reset_b     (in)         asynchronous active-low reset
//   enable      (in)         gates the generator; out_valid follows one cycle later
//   load        (in)         seed load strobe
//   seed        (in,  WIDTH) seed value sampled when load=1
//   out_data    (out, WIDTH) current LFSR state
//   out_valid   (out)        out_data is available
//   out_ready   (in)         downstream accepts out_data
//   seed_fixed  (out)        one-cycle pulse: a zero seed was replaced
// Optional (macro LFSR_PERIOD_MON_EN):
//   period_done (out)        pulses when the state returns to its start value
//   step_count  (out, 32)    single steps since the last reset/load
module lfsr_noise_gen
  import lfsr_pkg::*;
#(
  parameter int         WIDTH      = 8,
  parameter lfsr_word_t TAPS       = 32'h0000_00B8,
  parameter int         SHIFTS     = 1,
  parameter lfsr_word_t RESET_SEED = DEFAULT_SEED
) (
  input  logic             clock,
  input  logic             reset_b,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             seed_fixed
`ifdef LFSR_PERIOD_MON_EN
  ,
  output logic             period_done,
  output logic [31:0]      step_count
`endif
);

  localparam logic [WIDTH-1:0] TAPS_W = TAPS[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED_W = RESET_SEED[WIDTH-1:0];

  // Configuration sanity: a mask without the top bit shortens the register
  // and a zero mask or zero reset seed locks the generator at zero.
  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("lfsr_noise_gen: WIDTH out of range 3..32");
  end
  if (SHIFTS < 1 || SHIFTS > WIDTH) begin : g_bad_shifts
    $error("lfsr_noise_gen: SHIFTS out of range 1..WIDTH");
  end
  if (TAPS_W == '0 || !TAPS_W[WIDTH-1]) begin : g_bad_taps
    $error("lfsr_noise_gen: TAPS must be nonzero with bit WIDTH-1 set");
  end
  if (SEED_W == '0) begin : g_bad_seed
    $error("lfsr_noise_gen: RESET_SEED must be nonzero");
  end

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] advanced;
  logic             transfer;
  logic             seed_zero;
  logic [WIDTH-1:0] load_value;

  lfsr_multi_step #(
    .WIDTH  (WIDTH),
    .TAPS   (lfsr_word_t'(TAPS_W)),
    .SHIFTS (SHIFTS)
  ) u_multi_step (
    .state_in  (state_q),
    .state_out (advanced)
  );

  assign transfer   = out_valid && out_ready;
  assign seed_zero  = (seed == '0);
  assign load_value = seed_zero ? SEED_W : seed;
  assign out_data   = state_q;

  // Load wins over a coinciding transfer: the word on out_data is still
  // consumed downstream, but the register takes the seed instead of the
  // advanced value. The state only moves on an accepted word, so a low
  // enable freezes it once out_valid has dropped.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state_q    <= SEED_W;
      out_valid  <= 1'b0;
      seed_fixed <= 1'b0;
    end else begin
      out_valid  <= enable;
      seed_fixed <= load && seed_zero;
      if (load) begin
        state_q <= load_value;
      end else if (transfer) begin
        state_q <= advanced;
      end
    end
  end

`ifdef LFSR_PERIOD_MON_EN
  logic [WIDTH-1:0] start_q;

  // The start value is whatever the register was last forced to; a word
  // boundary that lands back on it marks a completed period.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      start_q     <= SEED_W;
      step_count  <= 32'd0;
      period_done <= 1'b0;
    end else begin
      period_done <= 1'b0;
      if (load) begin
        start_q    <= load_value;
        step_count <= 32'd0;
      end else if (transfer) begin
        step_count  <= step_count + 32'(SHIFTS);
        period_done <= (advanced == start_q);
      end
    end
  end
`endif

endmodule

// File: doc/lfsr_noise_gen.md
Name: lfsr_noise_gen

Overview:
- Parametrised Fibonacci LFSR pseudo-noise source; next generation of the team's fixed 8-bit noise register.
- Width and tap mask are configurable. It advances multiple shifts per output word, supports runtime seed load with zero-seed protection, and delivers words over a valid/ready stream.
- Feeds noise/scrambler datapaths and test-pattern sources.

Parameters:
- WIDTH, 8, state and output word width (3..32).
- TAPS, 8'hB8, feedback mask; bit i set means state[i] is XORed into the new bit 0. Default gives x^8+x^6+x^5+x^4+1, period 255.
- SHIFTS, 1, LFSR steps applied per accepted word (1..WIDTH).
- RESET_SEED, 1, state value loaded on reset; must be nonzero.

Ports:
- clock  in  1  system clock.
- reset_b  in  1  asynchronous, active-low reset.
- enable  in  1  gates the generator; when low, the state is frozen and out_valid is low.
- load  in  1  single-cycle seed load strobe.
- seed  in  WIDTH  seed value, sampled when load=1.
- out_data  out  WIDTH  current LFSR state.
- out_valid  out  1  out_data is available.
- out_ready  in  1  downstream accepts out_data.
- seed_fixed  out  1  one-cycle pulse: a zero seed was replaced.

Behaviour:
- Reset:
  - Asynchronous, active-low reset on reset_b; the block is clocked by clock.
  - Reset values: state=RESET_SEED, out_valid=0, seed_fixed=0.
- Single step:
  - next[0] = XOR-reduce(state & TAPS).
  - next[i] = state[i-1] for i=1..WIDTH-1.
- Word advance:
  - One accepted word advances the state by SHIFTS steps, combinationally unrolled, within one cycle.
  - There is no multi-cycle latency.
- out_valid:
  - Registered; equals enable delayed by one cycle, and is cleared by reset.
  - The first word (RESET_SEED) is offered on the first cycle after reset release with enable=1.
- Transfer:
  - A transfer occurs on a cycle with out_valid && out_ready.
  - The state advances SHIFTS steps at that clock edge.
  - If out_ready=0, the state and out_data are held stable (AXI-style, no change while stalled).
- Enable:
  - enable=0 freezes the state and, from the next cycle, drops out_valid.
  - A transfer already qualified in the current cycle still completes.
- Load:
  - load=1 sets state <= seed regardless of enable and out_ready.
  - If load and a transfer coincide, the transfer completes with the old out_data, and the state takes the seed, not the advanced value.
  - Load does not change out_valid.
- Zero-seed guard:
  - If load=1 and seed==0, the state takes RESET_SEED instead, and seed_fixed pulses high for exactly one cycle.
  - The all-zero state is therefore unreachable.
- Reset mid-operation: takes effect immediately and asynchronously; any pending word is discarded.
- Width rules:
  - TAPS and seed are truncated to WIDTH.
  - TAPS==0 or a TAPS without bit WIDTH-1 set is a configuration error, flagged by an elaboration-time assertion.

Optional Feature:
- Macro: LFSR_PERIOD_MON_EN.
- With it defined:
  - Extra ports period_done (out, 1) and step_count (out, 32).
  - step_count counts total single steps since the last reset/load, wrapping at 2^32.
  - period_done pulses for one cycle when, after a transfer, the state equals the value captured at the last reset/load.
  - With SHIFTS>1 the check applies only at word boundaries.
- Without it: no ports, no counter logic.

Decomposition:
- Package lfsr_pkg:
  - Default tap masks for widths 3..32 (maximal-length table).
  - Constant DEFAULT_SEED=1.
  - Function lfsr_step(state, taps) for a single step.
- Sub-module lfsr_multi_step: combinational, WIDTH/TAPS/SHIFTS parameters; chains SHIFTS lfsr_step calls.
- The top level holds the state register, handshake, load/guard and optional monitor.

Test Plan:
- Reset sequence: defaults, enable=1, out_ready=1 after reset → out_data sequence 01,02,04,08,11,23,47,8E,1C; out_valid rises one cycle after reset release.
- Backpressure: out_ready low for 5 cycles while out_data=0x08 → out_data is held at 0x08 throughout; with out_ready=1 the next word is 0x11.
- Seed load:
  - load=1, seed=0x5A during a transfer → the transfer returns the old word; the next out_data is 0x5A.
  - load with seed=0x00 → state 0x01, seed_fixed high for one cycle.
- Multi-step: SHIFTS=8 from 0x01 → the first accepted word is 0x01, the next word is 0x1C.
- Period (LFSR_PERIOD_MON_EN): defaults, free-running → period_done pulses exactly at step_count=255 and 510; no all-zero state is ever observed.
- Enable/reset interplay:
  - enable=0 mid-stream → the state freezes and out_valid drops the next cycle.
  - reset_b asserted asynchronously mid-cycle → out_valid=0 and state=0x01 immediately.
